// File: rtl/slc3_trace_buffer.sv
// slc3_trace_buffer: instruction fetch trace buffer for the SLC-3 core.
// Captures {PC, IR} pairs into a circular buffer, optionally starting on a
// trigger opcode, with wrap (overwrite-oldest) or stop-when-full policies.
// Reads pop the oldest entry with a registered one-cycle response.
module slc3_trace_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Clear,
  input  logic                Trace_en,
  input  logic                Trigger_en,
  input  logic [3:0]          Trigger_opcode,
  input  logic                Wrap_mode,
  input  logic                Fetch_valid,
  input  logic [DATA_W-1:0]   PC_in,
  input  logic [DATA_W-1:0]   IR_in,
  input  logic                Rd_req,
  output logic [2*DATA_W-1:0] Rd_data,
  output logic                Rd_valid,
  output logic [CNT_W-1:0]    Count,
  output logic                Full,
  output logic                Empty,
  output logic                Overflow,
  output logic                Triggered,
  output logic [1:0]          State
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    STOPPED = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 triggered_q, triggered_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [2*DATA_W-1:0]  rd_data_q, rd_data_d;

  logic [2*DATA_W-1:0]  mem_q [DEPTH];

  logic full, empty;
  logic opcode_match;
  logic capture_ok;
  logic rd_fire;
  logic wr_store;
  logic wr_overwrite;
  logic wr_drop_full;
  logic mem_we;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  assign opcode_match = (IR_in[DATA_W-1 -: 4] == Trigger_opcode);

  // Classify this cycle's fetch and read; a read is resolved before a write,
  // so a full buffer with a concurrent pop accepts the write without loss.
  always_comb begin
    capture_ok   = 1'b0;
    rd_fire      = 1'b0;
    wr_store     = 1'b0;
    wr_overwrite = 1'b0;
    wr_drop_full = 1'b0;
    if (!Clear) begin
      rd_fire    = Rd_req && !empty;
      capture_ok = Trace_en && Fetch_valid &&
                   ((state_q == CAPTURE) || ((state_q == ARMED) && opcode_match));
      if (capture_ok) begin
        if (!full || rd_fire) begin
          wr_store = 1'b1;
        end else if (Wrap_mode) begin
          wr_store     = 1'b1;
          wr_overwrite = 1'b1;
        end else begin
          wr_drop_full = 1'b1;
        end
      end
    end
  end

  assign mem_we = wr_store;

  // Datapath next-state: pointers, occupancy, sticky flags and read response.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    triggered_d = triggered_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    if (Clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      triggered_d = 1'b0;
    end else begin
      if (rd_fire) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      if (wr_store) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_fire || wr_overwrite) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(wr_store && !wr_overwrite) - CNT_W'(rd_fire);
      if (wr_overwrite || wr_drop_full) begin
        overflow_d = 1'b1;
      end
      if ((state_q == ARMED) && capture_ok) begin
        triggered_d = 1'b1;
      end
    end
  end

  // Session FSM next-state; disabling the trace always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (Clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Trace_en) begin
            state_d = Trigger_en ? ARMED : CAPTURE;
          end
        end
        ARMED: begin
          if (!Trace_en) begin
            state_d = IDLE;
          end else if (capture_ok) begin
            state_d = wr_drop_full ? STOPPED : CAPTURE;
          end
        end
        CAPTURE: begin
          if (!Trace_en) begin
            state_d = IDLE;
          end else if (wr_drop_full) begin
            state_d = STOPPED;
          end
        end
        STOPPED: begin
          if (!Trace_en) begin
            state_d = IDLE;
          end else if (rd_fire || !full) begin
            state_d = CAPTURE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and response registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      triggered_q <= triggered_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Trace storage; contents are not reset.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= {PC_in, IR_in};
    end
  end

  assign Rd_data   = rd_data_q;
  assign Rd_valid  = rd_valid_q;
  assign Count     = count_q;
  assign Full      = full;
  assign Empty     = empty;
  assign Overflow  = overflow_q;
  assign Triggered = triggered_q;
  assign State     = state_q;

endmodule

// File: tb/tb_slc3_trace_buffer.sv
// Directed testbench for slc3_trace_buffer (DEPTH=4, DATA_W=16).
module tb_slc3_trace_buffer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Clear = 1'b0;
  logic        Trace_en = 1'b0;
  logic        Trigger_en = 1'b0;
  logic [3:0]  Trigger_opcode = 4'h0;
  logic        Wrap_mode = 1'b0;
  logic        Fetch_valid = 1'b0;
  logic [15:0] PC_in = 16'h0;
  logic [15:0] IR_in = 16'h0;
  logic        Rd_req = 1'b0;
  logic [31:0] Rd_data;
  logic        Rd_valid;
  logic [2:0]  Count;
  logic        Full;
  logic        Empty;
  logic        Overflow;
  logic        Triggered;
  logic [1:0]  State;

  int checks = 0;
  int errors = 0;

  slc3_trace_buffer #(.DATA_W(16), .DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .Trace_en(Trace_en),
    .Trigger_en(Trigger_en), .Trigger_opcode(Trigger_opcode),
    .Wrap_mode(Wrap_mode), .Fetch_valid(Fetch_valid), .PC_in(PC_in),
    .IR_in(IR_in), .Rd_req(Rd_req), .Rd_data(Rd_data), .Rd_valid(Rd_valid),
    .Count(Count), .Full(Full), .Empty(Empty), .Overflow(Overflow),
    .Triggered(Triggered), .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_fetch(input logic [15:0] pc, input logic [15:0] ir);
    Fetch_valid = 1'b1; PC_in = pc; IR_in = ir;
    tick();
    Fetch_valid = 1'b0;
  endtask

  task automatic do_read(output logic v, output logic [31:0] d);
    Rd_req = 1'b1;
    tick();
    Rd_req = 1'b0;
    v = Rd_valid;
    d = Rd_data;
  endtask

  task automatic do_clear();
    Trace_en = 1'b0; Clear = 1'b1;
    tick();
    Clear = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    checks++; if (State !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", State); end
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", Count); end
    checks++; if (Empty !== 1'b1 || Full !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got E=%b F=%b expected E=1 F=0", Empty, Full); end
    checks++; if (Overflow !== 1'b0 || Triggered !== 1'b0) begin errors++; $display("FAIL reset_flags: got O=%b T=%b expected 0 0", Overflow, Triggered); end
    checks++; if (Rd_valid !== 1'b0 || Rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd: got v=%b d=%h expected 0 00000000", Rd_valid, Rd_data); end
  endtask

  task automatic test_basic();
    logic v; logic [31:0] d;
    do_clear();
    Trigger_en = 1'b0; Wrap_mode = 1'b1; Trace_en = 1'b1;
    tick();
    checks++; if (State !== 2'd2) begin errors++; $display("FAIL basic_state: got %0d expected 2", State); end
    for (int i = 0; i < 3; i++) do_fetch(16'h3000 + 16'(i), 16'h1000 + 16'(i));
    checks++; if (Count !== 3'd3 || Empty !== 1'b0) begin errors++; $display("FAIL basic_count: got %0d E=%b expected 3 E=0", Count, Empty); end
    for (int i = 0; i < 3; i++) begin
      do_read(v, d);
      checks++; if (v !== 1'b1 || d !== {16'h3000 + 16'(i), 16'h1000 + 16'(i)}) begin errors++; $display("FAIL basic_read%0d: got v=%b d=%h expected v=1 d=%h", i, v, d, {16'h3000 + 16'(i), 16'h1000 + 16'(i)}); end
    end
    checks++; if (Empty !== 1'b1 || Count !== 3'd0) begin errors++; $display("FAIL basic_empty: got E=%b C=%0d expected E=1 C=0", Empty, Count); end
    tick();
    checks++; if (Rd_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", Rd_valid); end
  endtask

  task automatic test_trigger();
    logic v; logic [31:0] d;
    do_clear();
    Trigger_en = 1'b1; Trigger_opcode = 4'h9; Wrap_mode = 1'b1; Trace_en = 1'b1;
    tick();
    checks++; if (State !== 2'd1) begin errors++; $display("FAIL trig_armed: got %0d expected 1", State); end
    do_fetch(16'h3000, 16'h1021);
    do_fetch(16'h3001, 16'h5020);
    checks++; if (Count !== 3'd0 || Triggered !== 1'b0) begin errors++; $display("FAIL trig_discard: got C=%0d T=%b expected 0 0", Count, Triggered); end
    do_fetch(16'h3002, 16'h9FFF);
    checks++; if (State !== 2'd2 || Triggered !== 1'b1) begin errors++; $display("FAIL trig_fire: got S=%0d T=%b expected 2 1", State, Triggered); end
    do_fetch(16'h3003, 16'h0E01);
    checks++; if (Count !== 3'd2) begin errors++; $display("FAIL trig_count: got %0d expected 2", Count); end
    do_read(v, d);
    checks++; if (v !== 1'b1 || d !== 32'h30029FFF) begin errors++; $display("FAIL trig_read0: got v=%b d=%h expected v=1 d=30029fff", v, d); end
    do_read(v, d);
    checks++; if (v !== 1'b1 || d !== 32'h30030E01) begin errors++; $display("FAIL trig_read1: got v=%b d=%h expected v=1 d=30030e01", v, d); end
  endtask

  task automatic test_wrap();
    logic v; logic [31:0] d;
    do_clear();
    Trigger_en = 1'b0; Wrap_mode = 1'b1; Trace_en = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) do_fetch(16'h3000 + 16'(i), 16'h2000 + 16'(i));
    checks++; if (Count !== 3'd4 || Full !== 1'b1 || Overflow !== 1'b1) begin errors++; $display("FAIL wrap_status: got C=%0d F=%b O=%b expected 4 1 1", Count, Full, Overflow); end
    for (int i = 2; i < 6; i++) begin
      do_read(v, d);
      checks++; if (v !== 1'b1 || d !== {16'h3000 + 16'(i), 16'h2000 + 16'(i)}) begin errors++; $display("FAIL wrap_read%0d: got v=%b d=%h expected v=1 d=%h", i, v, d, {16'h3000 + 16'(i), 16'h2000 + 16'(i)}); end
    end
  endtask

  task automatic test_stop();
    logic v; logic [31:0] d;
    do_clear();
    Trigger_en = 1'b0; Wrap_mode = 1'b0; Trace_en = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) do_fetch(16'h3000 + 16'(i), 16'h3000 + 16'(i));
    checks++; if (State !== 2'd3 || Count !== 3'd4 || Overflow !== 1'b1) begin errors++; $display("FAIL stop_status: got S=%0d C=%0d O=%b expected 3 4 1", State, Count, Overflow); end
    do_read(v, d);
    checks++; if (v !== 1'b1 || d !== 32'h30003000) begin errors++; $display("FAIL stop_read0: got v=%b d=%h expected v=1 d=30003000", v, d); end
    checks++; if (State !== 2'd2 || Count !== 3'd3) begin errors++; $display("FAIL stop_recover: got S=%0d C=%0d expected 2 3", State, Count); end
    do_fetch(16'h3006, 16'h3006);
    checks++; if (Count !== 3'd4) begin errors++; $display("FAIL stop_refill: got %0d expected 4", Count); end
    for (int i = 1; i < 5; i++) begin
      do_read(v, d);
      checks++; if (v !== 1'b1 || d[31:16] !== ((i == 4) ? 16'h3006 : 16'h3000 + 16'(i))) begin errors++; $display("FAIL stop_read%0d: got v=%b pc=%h expected v=1 pc=%h", i, v, d[31:16], (i == 4) ? 16'h3006 : 16'h3000 + 16'(i)); end
    end
  endtask

  task automatic test_boundary();
    logic v; logic [31:0] d;
    do_clear();
    Trigger_en = 1'b0; Wrap_mode = 1'b0; Trace_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) do_fetch(16'h3000 + 16'(i), 16'h4000 + 16'(i));
    Rd_req = 1'b1; Fetch_valid = 1'b1; PC_in = 16'h3004; IR_in = 16'h4004;
    tick();
    Rd_req = 1'b0; Fetch_valid = 1'b0;
    checks++; if (Rd_valid !== 1'b1 || Rd_data !== 32'h30004000) begin errors++; $display("FAIL bnd_rw_full_read: got v=%b d=%h expected v=1 d=30004000", Rd_valid, Rd_data); end
    checks++; if (Count !== 3'd4 || Overflow !== 1'b0 || State !== 2'd2) begin errors++; $display("FAIL bnd_rw_full: got C=%0d O=%b S=%0d expected 4 0 2", Count, Overflow, State); end
    for (int i = 1; i < 5; i++) begin
      do_read(v, d);
      checks++; if (v !== 1'b1 || d !== {16'h3000 + 16'(i), 16'h4000 + 16'(i)}) begin errors++; $display("FAIL bnd_drain%0d: got v=%b d=%h expected v=1 d=%h", i, v, d, {16'h3000 + 16'(i), 16'h4000 + 16'(i)}); end
    end
    do_read(v, d);
    checks++; if (v !== 1'b0 || d !== 32'h30044004) begin errors++; $display("FAIL bnd_empty_read: got v=%b d=%h expected v=0 d=30044004", v, d); end
    Rd_req = 1'b1; Fetch_valid = 1'b1; PC_in = 16'h3010; IR_in = 16'h4010;
    tick();
    Rd_req = 1'b0; Fetch_valid = 1'b0;
    checks++; if (Count !== 3'd1 || Rd_valid !== 1'b0) begin errors++; $display("FAIL bnd_rw_empty: got C=%0d v=%b expected 1 0", Count, Rd_valid); end
    do_read(v, d);
    checks++; if (v !== 1'b1 || d !== 32'h30104010) begin errors++; $display("FAIL bnd_rw_empty_read: got v=%b d=%h expected v=1 d=30104010", v, d); end
  endtask

  task automatic test_clear();
    do_clear();
    Trigger_en = 1'b1; Trigger_opcode = 4'h9; Wrap_mode = 1'b1; Trace_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) do_fetch(16'h3000 + 16'(i), 16'h9000 + 16'(i));
    checks++; if (Count !== 3'd4 || Overflow !== 1'b1 || Triggered !== 1'b1) begin errors++; $display("FAIL clr_setup: got C=%0d O=%b T=%b expected 4 1 1", Count, Overflow, Triggered); end
    Clear = 1'b1; Fetch_valid = 1'b1; PC_in = 16'h3100; IR_in = 16'h9100;
    tick();
    Clear = 1'b0; Fetch_valid = 1'b0;
    checks++; if (Count !== 3'd0 || Empty !== 1'b1 || Full !== 1'b0) begin errors++; $display("FAIL clr_count: got C=%0d E=%b F=%b expected 0 1 0", Count, Empty, Full); end
    checks++; if (Overflow !== 1'b0 || Triggered !== 1'b0 || State !== 2'd0 || Rd_valid !== 1'b0) begin errors++; $display("FAIL clr_flags: got O=%b T=%b S=%0d v=%b expected 0 0 0 0", Overflow, Triggered, State, Rd_valid); end
  endtask

  task automatic test_reset_mid();
    do_clear();
    Trigger_en = 1'b0; Wrap_mode = 1'b1; Trace_en = 1'b1;
    tick();
    do_fetch(16'h3000, 16'h5000);
    do_fetch(16'h3001, 16'h5001);
    Rd_req = 1'b1; Fetch_valid = 1'b1; PC_in = 16'h3002; IR_in = 16'h5002;
    #2 Reset = 1'b1;
    #1;
    checks++; if (Count !== 3'd0 || State !== 2'd0 || Empty !== 1'b1) begin errors++; $display("FAIL rst_async: got C=%0d S=%0d E=%b expected 0 0 1", Count, State, Empty); end
    checks++; if (Rd_valid !== 1'b0 || Rd_data !== 32'h0) begin errors++; $display("FAIL rst_async_rd: got v=%b d=%h expected 0 00000000", Rd_valid, Rd_data); end
    tick();
    Reset = 1'b0; Rd_req = 1'b0; Fetch_valid = 1'b0; Trace_en = 1'b0;
    tick();
    checks++; if (Rd_valid !== 1'b0 || Count !== 3'd0 || Overflow !== 1'b0) begin errors++; $display("FAIL rst_after: got v=%b C=%0d O=%b expected 0 0 0", Rd_valid, Count, Overflow); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trigger();
    test_wrap();
    test_stop();
    test_boundary();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slc3_trace_buffer.md
SLC3_TRACE_BUFFER -- requirements
Module: slc3_trace_buffer

Interface
REQ-001 Parameter DATA_W, default 16: width of each captured PC and IR value.
REQ-002 Parameter DEPTH, default 16: number of entries; a power of two, at least 2.
REQ-003 Parameter CNT_W, default $clog2(DEPTH)+1: width of Count.
REQ-004 Ports are listed as: name, direction, width, meaning.
- Clk  in  1  single clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Clear  in  1  synchronous flush of pointers, flags and state.
- Trace_en  in  1  level; capture session enable.
- Trigger_en  in  1  level; 1 = wait for the trigger opcode before capturing.
- Trigger_opcode  in  4  opcode that starts capture.
- Wrap_mode  in  1  1 = overwrite the oldest entry when full; 0 = stop when full.
- Fetch_valid  in  1  one-cycle strobe each time the IR is loaded.
- PC_in  in  DATA_W  PC of the fetched instruction.
- IR_in  in  DATA_W  fetched instruction word.
- Rd_req  in  1  pop the oldest entry.
- Rd_data  out  2*DATA_W  {PC, IR} of the popped entry.
- Rd_valid  out  1  Rd_data valid; one-cycle pulse.
- Count  out  CNT_W  number of occupied entries, 0..DEPTH.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.
- Overflow  out  1  sticky; at least one entry was lost or overwritten.
- Triggered  out  1  sticky; the trigger has fired in this session.
- State  out  2  FSM state encoding, for debug.

Function
REQ-005 The FSM shall have four states: IDLE=0, ARMED=1, CAPTURE=2, STOPPED=3.
REQ-006 In IDLE with Trace_en=1, the FSM shall move to ARMED if Trigger_en=1, otherwise to CAPTURE.
REQ-007 In ARMED, a Fetch_valid cycle with IR_in[DATA_W-1:DATA_W-4]==Trigger_opcode shall write that fetch, set Triggered and move the FSM to CAPTURE.
REQ-008 In ARMED, any non-matching fetch shall be discarded.
REQ-009 In CAPTURE, every Fetch_valid cycle shall write {PC_in, IR_in} at the write pointer.
REQ-010 A write to a full buffer with Wrap_mode=1 shall overwrite the oldest entry, advance the read pointer, hold Count at DEPTH and set Overflow.
REQ-011 A write to a full buffer with Wrap_mode=0 shall drop the fetch, set Overflow and move the FSM to STOPPED.
REQ-012 In STOPPED, fetches shall be dropped.
REQ-013 STOPPED shall return to CAPTURE in the cycle after a read makes Count < DEPTH.
REQ-014 Trace_en=0 in any non-IDLE state shall return the FSM to IDLE; buffer contents and flags shall be retained.
REQ-015 Rd_req with Empty=0 shall pop the oldest entry, and Rd_data/Rd_valid shall be registered one cycle after Rd_req.
REQ-016 Rd_req with Empty=1 shall be ignored, with Rd_valid=0 and Rd_data held.
REQ-017 Reads shall be honoured in every state.
REQ-018 A simultaneous read and write shall process the read first: Count unchanged, no overwrite, Overflow not set, even when full.
REQ-019 A simultaneous read and write on an empty buffer: the write is stored, the read is ignored, and Count becomes 1.
REQ-020 Pointers shall be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-021 Count shall be combinationally consistent with Full and Empty in the same cycle.
REQ-022 Clear shall take priority over all other inputs: pointers=0, Count=0, Overflow=0, Triggered=0, Rd_valid=0, FSM=IDLE.
REQ-023 A fetch coincident with Clear shall be discarded.
REQ-024 Changing Wrap_mode or Trigger_opcode mid-session shall take effect on the next fetch.

Reset
REQ-025 Reset shall asynchronously force: FSM=IDLE, pointers=0, Count=0, Empty=1, Full=0, Overflow=0, Triggered=0, Rd_valid=0, Rd_data=0.
REQ-026 Storage array contents shall not be required to reset.
REQ-027 Reset asserted mid-operation shall abort any capture or pending read; Rd_valid=0 in the cycle after reset deasserts.

Verification (DEPTH=4, DATA_W=16)
REQ-028 Basic capture: Trace_en=1, Trigger_en=0, fetches PC=x3000..x3002 -> Count=3; three Rd_req return x3000, x3001, x3002 in order with one-cycle latency; then Empty=1.
REQ-029 Trigger: Trigger_en=1, Trigger_opcode=x9, fetch IR values x1021, x5020, x9FFF, x0E01 -> only x9FFF and x0E01 are stored; Triggered=1; Count=2.
REQ-030 Wrap: Wrap_mode=1, six fetches PC=x3000..x3005 -> Count=4, Overflow=1; reads return x3002..x3005.
REQ-031 Stop: Wrap_mode=0, six fetches PC=x3000..x3005 -> FSM=STOPPED, Count=4, Overflow=1; reads return x3000..x3003.
REQ-032 Stop recovery: after one read from STOPPED, FSM=CAPTURE on the next cycle and the next fetch is stored.
REQ-033 Boundaries: full buffer with simultaneous Rd_req and Fetch_valid -> Count stays 4, Overflow stays 0; Rd_req on empty -> Rd_valid=0.
REQ-034 Clear and Reset: Clear or Reset asserted mid-capture -> all flags 0, Count=0, FSM=IDLE; the coincident fetch is not stored.
